// File: rtl/wash_pkg.sv
// Shared types and defaults for the washing-machine controller and its plant model.
package wash_pkg;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_CYCLE_RUN  = 3'd1,
    PH_CYCLE_DONE = 3'd2,
    PH_SPIN_RUN   = 3'd3,
    PH_SPIN_DONE  = 3'd4
  } phase_t;

  // Controller-side encodings, so both ends of the loop agree on state numbering.
  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_FILL      = 3'd1,
    CTRL_DETERGENT = 3'd2,
    CTRL_WASH      = 3'd3,
    CTRL_DRAIN     = 3'd4,
    CTRL_SPIN      = 3'd5
  } ctrl_state_t;

  localparam int DEF_FULL_LEVEL  = 8;
  localparam int DEF_RATE_DIV    = 2;
  localparam int DEF_CYCLE_TICKS = 10;
  localparam int DEF_SPIN_TICKS  = 5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wash_level_tank.sv
// Water tank: prescaled, saturating level counter with Filled/Drained decode.
module wash_level_tank
  import wash_pkg::*;
#(
  parameter int FULL_LEVEL = DEF_FULL_LEVEL,
  parameter int RATE_DIV   = DEF_RATE_DIV,
  localparam int LW = $clog2(FULL_LEVEL + 1),
  localparam int PW = $clog2(RATE_DIV + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Fill_valve_on,
  input  logic          Drained_valve_on,
  output logic [LW-1:0] Water_Level,
  output logic          Filled,
  output logic          Drained
);

  logic [PW-1:0] presc_reg, presc_next;
  logic [LW-1:0] level_reg, level_next;

  // Prescaler only runs with exactly one valve open; off or both-open clears it.
  always_comb begin
    presc_next = '0;
    level_next = level_reg;
    if (Fill_valve_on ^ Drained_valve_on) begin
      if (presc_reg == PW'(RATE_DIV - 1)) begin
        presc_next = '0;
        if (Fill_valve_on && (level_reg != LW'(FULL_LEVEL)))
          level_next = level_reg + LW'(1);
        else if (Drained_valve_on && (level_reg != '0))
          level_next = level_reg - LW'(1);
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc_reg <= '0;
      level_reg <= '0;
    end else begin
      presc_reg <= presc_next;
      level_reg <= level_next;
    end
  end

  assign Water_Level = level_reg;
  assign Filled      = (level_reg == LW'(FULL_LEVEL));
  assign Drained     = (level_reg == '0);

endmodule

// File: rtl/wash_plant_model.sv
// Plant responder for the wash controller: tank, detergent latch, cycle/spin timers, fault flag.
module wash_plant_model
  import wash_pkg::*;
#(
  parameter int FULL_LEVEL  = DEF_FULL_LEVEL,
  parameter int RATE_DIV    = DEF_RATE_DIV,
  parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Motor_on,
  input  logic                             Fill_valve_on,
  input  logic                             Drained_valve_on,
  input  logic                             Door_Lock,
  input  logic                             Dispense,
  output logic                             Filled,
  output logic                             Drained,
  output logic                             Detergent_Added,
  output logic                             Cycle_Timeout,
  output logic                             Spin_Timeout,
  output logic [$clog2(FULL_LEVEL+1)-1:0]  Water_Level,
  output logic                             Fault
);

  localparam int TW = $clog2(max2(CYCLE_TICKS, SPIN_TICKS) + 1);

  phase_t        phase_reg, phase_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          det_reg, fault_reg;
  logic          spin_tick;

  wash_level_tank #(
    .FULL_LEVEL (FULL_LEVEL),
    .RATE_DIV   (RATE_DIV)
  ) u_tank (
    .Clock            (Clock),
    .Reset            (Reset),
    .Fill_valve_on    (Fill_valve_on),
    .Drained_valve_on (Drained_valve_on),
    .Water_Level      (Water_Level),
    .Filled           (Filled),
    .Drained          (Drained)
  );

  // Spin only advances while the drain is open on an empty tank.
  assign spin_tick = Drained_valve_on && Drained;

  always_comb begin
    phase_next = phase_reg;
    timer_next = timer_reg;
    if (!Door_Lock) begin
      phase_next = PH_IDLE;
      timer_next = '0;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          timer_next = '0;
          if (Motor_on) begin
            timer_next = TW'(1);
            phase_next = (CYCLE_TICKS == 1) ? PH_CYCLE_DONE : PH_CYCLE_RUN;
          end
        end
        PH_CYCLE_RUN: begin
          if (Motor_on) begin
            timer_next = timer_reg + TW'(1);
            if (timer_reg == TW'(CYCLE_TICKS - 1))
              phase_next = PH_CYCLE_DONE;
          end
        end
        PH_CYCLE_DONE: begin
          if (spin_tick) begin
            timer_next = TW'(1);
            phase_next = (SPIN_TICKS == 1) ? PH_SPIN_DONE : PH_SPIN_RUN;
          end
        end
        PH_SPIN_RUN: begin
          if (spin_tick) begin
            timer_next = timer_reg + TW'(1);
            if (timer_reg == TW'(SPIN_TICKS - 1))
              phase_next = PH_SPIN_DONE;
          end
        end
        PH_SPIN_DONE: ;
        default: begin
          phase_next = PH_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_reg <= PH_IDLE;
      timer_reg <= '0;
      det_reg   <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      timer_reg <= timer_next;
      if (!Door_Lock)
        det_reg <= 1'b0;
      else if (Dispense)
        det_reg <= 1'b1;
      if ((Fill_valve_on && Drained_valve_on) || (Fill_valve_on && !Door_Lock))
        fault_reg <= 1'b1;
    end
  end

  assign Detergent_Added = det_reg;
  assign Fault           = fault_reg;
  assign Cycle_Timeout   = (phase_reg == PH_CYCLE_DONE);
  assign Spin_Timeout    = (phase_reg == PH_SPIN_DONE);

endmodule

// File: tb/tb_wash_plant_model.sv
// Bench for wash_plant_model: directed scenarios, random soak and a closed-loop wash against a behavioural model.
module tb_wash_plant_model;
  import wash_pkg::*;

  localparam int FL = 8;
  localparam int RD = 2;
  localparam int CT = 10;
  localparam int ST = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Motor_on = 1'b0, Fill_valve_on = 1'b0, Drained_valve_on = 1'b0;
  logic Door_Lock = 1'b0, Dispense = 1'b0;
  logic Filled, Drained, Detergent_Added, Cycle_Timeout, Spin_Timeout, Fault;
  logic [$clog2(FL+1)-1:0] Water_Level;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state: level, clocks since last level step, counted wash clocks, counted spin clocks.
  int m_level = 0, m_pcnt = 0, m_cyc = 0, m_spin = 0;
  bit m_det = 1'b0, m_fault = 1'b0;

  always #5 Clock = ~Clock;

  wash_plant_model #(
    .FULL_LEVEL  (FL),
    .RATE_DIV    (RD),
    .CYCLE_TICKS (CT),
    .SPIN_TICKS  (ST)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Motor_on         (Motor_on),
    .Fill_valve_on    (Fill_valve_on),
    .Drained_valve_on (Drained_valve_on),
    .Door_Lock        (Door_Lock),
    .Dispense         (Dispense),
    .Filled           (Filled),
    .Drained          (Drained),
    .Detergent_Added  (Detergent_Added),
    .Cycle_Timeout    (Cycle_Timeout),
    .Spin_Timeout     (Spin_Timeout),
    .Water_Level      (Water_Level),
    .Fault            (Fault)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit was_dry;
    was_dry = (m_level == 0);
    if (Reset) begin
      m_level = 0; m_pcnt = 0; m_cyc = 0; m_spin = 0; m_det = 0; m_fault = 0;
    end else begin
      if (Fill_valve_on ^ Drained_valve_on) begin
        m_pcnt++;
        if (m_pcnt == RD) begin
          m_pcnt = 0;
          if (Fill_valve_on) m_level = (m_level < FL) ? m_level + 1 : FL;
          else               m_level = (m_level > 0)  ? m_level - 1 : 0;
        end
      end else begin
        m_pcnt = 0;
      end
      if (Fill_valve_on && (Drained_valve_on || !Door_Lock)) m_fault = 1;
      if (!Door_Lock) begin
        m_det = 0; m_cyc = 0; m_spin = 0;
      end else begin
        if (Dispense) m_det = 1;
        if (m_cyc < CT) begin
          if (Motor_on) m_cyc++;
        end else if (m_spin < ST && Drained_valve_on && was_dry) begin
          m_spin++;
        end
      end
    end
  endtask

  always @(posedge Clock) model_step();

  always @(negedge Clock) begin
    if (cmp_en) begin
      check("level",     Water_Level,     m_level);
      check("filled",    Filled,          m_level == FL);
      check("drained",   Drained,         m_level == 0);
      check("detergent", Detergent_Added, m_det);
      check("cycle_to",  Cycle_Timeout,   (m_cyc >= CT) && (m_spin == 0));
      check("spin_to",   Spin_Timeout,    m_spin >= ST);
      check("fault",     Fault,           m_fault);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  initial begin
    ctrl_state_t cs;
    int  hold;
    int  done_cnt;
    int  budget;
    bit  finished;

    step(2);
    cmp_en = 1'b1;
    check("rst_level",   Water_Level, 0);
    check("rst_drained", Drained, 1);
    check("rst_filled",  Filled, 0);
    check("rst_fault",   Fault, 0);
    check("rst_spin",    Spin_Timeout, 0);
    Reset = 1'b0;

    // Fill from empty: 16 edges to full, then saturate.
    Door_Lock = 1'b1; Fill_valve_on = 1'b1;
    step(15);
    check("fill15_level", Water_Level, 7);
    check("fill15_filled", Filled, 0);
    step(1);
    check("fill16_level", Water_Level, 8);
    check("fill16_filled", Filled, 1);
    check("fill16_drained", Drained, 0);
    check("model_full", m_level, 8);
    step(4);
    check("fill_sat", Water_Level, 8);
    Fill_valve_on = 1'b0;

    // Wash timer with a pause in the middle.
    Motor_on = 1'b1; step(4);
    Motor_on = 1'b0; Dispense = 1'b1; step(1);
    Dispense = 1'b0; step(2);
    Motor_on = 1'b1; step(5);
    check("cyc9", Cycle_Timeout, 0);
    step(1);
    check("cyc10", Cycle_Timeout, 1);
    check("det_locked", Detergent_Added, 1);
    Motor_on = 1'b0;

    // Drain then spin, then unlock.
    Drained_valve_on = 1'b1;
    step(15);
    check("drain15", Drained, 0);
    step(1);
    check("drain16", Drained, 1);
    check("drain16_level", Water_Level, 0);
    step(4);
    check("spin4", Spin_Timeout, 0);
    step(1);
    check("spin5", Spin_Timeout, 1);
    Door_Lock = 1'b0; Drained_valve_on = 1'b0;
    step(1);
    check("unlock_spin", Spin_Timeout, 0);
    check("unlock_det", Detergent_Added, 0);

    // Both valves at level 3.
    pulse_reset();
    Door_Lock = 1'b1; Fill_valve_on = 1'b1;
    step(6);
    check("lvl3", Water_Level, 3);
    check("lvl3_nofault", Fault, 0);
    Drained_valve_on = 1'b1;
    step(4);
    check("both_level", Water_Level, 3);
    check("both_fault", Fault, 1);
    Fill_valve_on = 1'b0; Drained_valve_on = 1'b0;
    step(2);
    check("fault_sticky", Fault, 1);

    // Dispense only latches while locked.
    pulse_reset();
    Door_Lock = 1'b0; Dispense = 1'b1;
    step(2);
    check("disp_unlocked", Detergent_Added, 0);
    Door_Lock = 1'b1;
    step(1);
    check("disp_locked", Detergent_Added, 1);
    Dispense = 1'b0;

    // Random soak.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        hold             = $urandom_range(1, 25);
        Door_Lock        = ($urandom_range(0, 9) != 0);
        Fill_valve_on    = ($urandom_range(0, 2) == 0);
        Drained_valve_on = $urandom_range(0, 1) != 0;
        Motor_on         = $urandom_range(0, 1) != 0;
      end
      hold--;
      Dispense = ($urandom_range(0, 7) == 0);
      Reset    = ($urandom_range(0, 299) == 0);
      step(1);
    end
    Reset = 1'b0;

    // Closed loop with a simple controller.
    Motor_on = 0; Fill_valve_on = 0; Drained_valve_on = 0; Door_Lock = 0; Dispense = 0;
    pulse_reset();
    cs = CTRL_IDLE; done_cnt = 0; budget = 0; finished = 0;
    while (!finished && budget < 2000) begin
      @(negedge Clock);
      budget++;
      case (cs)
        CTRL_IDLE:      cs = CTRL_FILL;
        CTRL_FILL:      if (Filled) cs = CTRL_DETERGENT;
        CTRL_DETERGENT: if (Detergent_Added) cs = CTRL_WASH;
        CTRL_WASH:      if (Cycle_Timeout) cs = CTRL_DRAIN;
        CTRL_DRAIN:     if (Drained) cs = CTRL_SPIN;
        CTRL_SPIN:      if (Spin_Timeout) begin cs = CTRL_IDLE; done_cnt++; finished = 1; end
        default:        cs = CTRL_IDLE;
      endcase
      Door_Lock        = (cs != CTRL_IDLE);
      Fill_valve_on    = (cs == CTRL_FILL);
      Dispense         = (cs == CTRL_DETERGENT);
      Motor_on         = (cs == CTRL_WASH) || (cs == CTRL_SPIN);
      Drained_valve_on = (cs == CTRL_DRAIN) || (cs == CTRL_SPIN);
    end
    step(3);
    check("loop_finished", finished, 1);
    check("loop_done_once", done_cnt, 1);
    check("loop_fault", Fault, 0);
    check("loop_level", Water_Level, 0);
    check("loop_spin_low", Spin_Timeout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_plant_model.md
# wash_plant_model

- Plant-side responder for the washing-machine controller FSM: consumes the controller's actuator outputs and produces the sensor and timeout inputs the controller waits on.
- Models the water level, the detergent dispenser latch, the wash-cycle timer and the spin timer.
- Used as the closed-loop partner of the controller in system simulation and on the FPGA demo board, where real sensors are absent.

## Interface

Parameters:
- FULL_LEVEL, 8: water level, in units, at which Filled asserts (≥1).
- RATE_DIV, 2: clocks per one-unit level change (≥1).
- CYCLE_TICKS, 10: Motor_on-high clocks before Cycle_Timeout (≥1).
- SPIN_TICKS, 5: drained-spin clocks before Spin_Timeout (≥1).

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Motor_on  in  1  drum motor command from controller.
- Fill_valve_on  in  1  fill valve command.
- Drained_valve_on  in  1  drain valve command.
- Door_Lock  in  1  door lock command; low = wash ended / idle.
- Dispense  in  1  detergent drawer push (one or more clocks).
- Filled  out  1  Water_Level == FULL_LEVEL.
- Drained  out  1  Water_Level == 0.
- Detergent_Added  out  1  sticky dispenser latch.
- Cycle_Timeout  out  1  wash cycle elapsed.
- Spin_Timeout  out  1  spin elapsed.
- Water_Level  out  $clog2(FULL_LEVEL+1)  current level.
- Fault  out  1  sticky illegal-actuation flag.

## Operation

- Every output is a decode of registers only. There is no combinational path from any input to any output; this is required because the controller drives its actuators combinationally from these signals.
- Level prescaler:
  - Counts while exactly one valve is on.
  - Clears when neither valve is on, or when both are on.
  - On reaching RATE_DIV-1 it wraps to 0 and the level steps by one: +1 if Fill_valve_on, −1 if Drained_valve_on.
  - Level saturates at FULL_LEVEL and at 0; a step at a saturated bound is a no-op.
- Both valves on: level holds, prescaler clears, Fault sets.
- Fill_valve_on while Door_Lock=0: Fault sets. Fault clears only on Reset.
- Detergent latch: set on any clock with Dispense=1 and Door_Lock=1; cleared on any clock with Door_Lock=0. Dispense while unlocked is ignored.
- Phase FSM, states IDLE, CYCLE_RUN, CYCLE_DONE, SPIN_RUN, SPIN_DONE:
  - IDLE: timer=0. If Door_Lock and Motor_on, go to CYCLE_RUN with timer=1, or to CYCLE_DONE if CYCLE_TICKS=1.
  - CYCLE_RUN: timer increments on Motor_on-high clocks and holds when Motor_on is low (pause, no clear). The CYCLE_TICKS-th Motor_on clock goes to CYCLE_DONE.
  - CYCLE_DONE: Cycle_Timeout=1. When Drained_valve_on and Drained are both high, go to SPIN_RUN with timer=1, or to SPIN_DONE if SPIN_TICKS=1.
  - SPIN_RUN: timer increments on clocks with Drained_valve_on and Drained both high, and holds otherwise. The SPIN_TICKS-th counted clock goes to SPIN_DONE.
  - SPIN_DONE: Spin_Timeout=1.
  - From any state, Door_Lock=0 → IDLE with timer cleared. Door_Lock=0 takes priority over every other transition.
- Cycle_Timeout is high only in CYCLE_DONE. Spin_Timeout is high only in SPIN_DONE.
- Water level is independent of the phase FSM and of Door_Lock.

## Timing

- Reset values:
  - Water_Level=0, Drained=1, Filled=0.
  - Detergent_Added=0, Cycle_Timeout=0, Spin_Timeout=0, Fault=0.
  - FSM=IDLE, prescaler=0, timer=0.
- Reset mid-operation overrides all inputs and clears all state on that edge.
- Fill latency from empty: Filled rises exactly FULL_LEVEL·RATE_DIV edges after Fill_valve_on first samples high with the valve held on.
- Drain latency from full: Drained rises after FULL_LEVEL·RATE_DIV edges.
- Cycle_Timeout rises on the edge that samples the CYCLE_TICKS-th Motor_on-high clock.
- End of wash handshake:
  - At the controller's last spin clock, Spin_Timeout=1 drives Door_Lock low.
  - On the next edge this block returns to IDLE, so Spin_Timeout drops, while the controller enters its idle state on the same edge.
- Timer width is $clog2(max(CYCLE_TICKS,SPIN_TICKS)+1). Prescaler width is $clog2(RATE_DIV+1).

## Structure

- Shared package wash_pkg holds:
  - the phase-state enum;
  - the controller state encodings, which tests use to cross-check both ends;
  - the default tick constants.
- One sub-module, wash_level_tank: prescaler, saturating level counter, Filled/Drained decode. The FSM, timer, detergent latch and Fault logic stay at top level.

## Test plan

Use FULL_LEVEL=8, RATE_DIV=2, CYCLE_TICKS=10, SPIN_TICKS=5.

1. Reset, then hold Fill_valve_on=1 → Water_Level steps every 2 clocks; Filled=1 and Drained=0 after 16 edges. Level stays at 8 thereafter.
2. Door_Lock=1, Motor_on high 4 clocks, low 3, high 6 → Cycle_Timeout=1 after the 10th high clock, not before.
3. From CYCLE_DONE at level 8, Drained_valve_on=1 → Drained after 16 edges. Spin_Timeout=1 after 5 further clocks. Dropping Door_Lock gives Spin_Timeout=0 and Detergent_Added=0 on the next edge.
4. Fill_valve_on and Drained_valve_on both 1 at level 3 → level holds at 3, Fault=1, and Fault stays 1 after the valves clear.
5. Dispense with Door_Lock=0 → Detergent_Added stays 0. Dispense with Door_Lock=1 → Detergent_Added=1 on the next edge.
6. Closed loop with the controller: Start and Door_Close, full wash → controller returns to idle with Done pulsed once, Fault=0, and the level returns to 0.
